// File: rtl/mpa_sequencer.sv
// mpa_sequencer: Moore microprogram automaton. A host loads microinstruction
// words into an internal memory while idle, then pulses start. Each cycle in
// RUN, the word at pc drives out and selects the next pc (NEXT, BR, WAIT, STOP).
//
// Word layout, MSB to LSB: OUT[OUT_W] OP[2] SEL[SEL_W] INV[1] TGT[ADDR_W]
//
// Ports:
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset (memory contents are kept)
//   x          condition inputs, one selected per word by SEL
//   start      begin at address 0 (IDLE only)
//   abort      synchronous return to IDLE, beats any opcode, no done
//   prog_we    write strobe for prog_addr/prog_data (IDLE only)
//   out        OUT field of mem[pc] while running, 0 when idle
//   busy       high in RUN
//   done       one-cycle registered pulse after a STOP executes
//   pc         current microprogram address
module mpa_sequencer #(
  parameter int ADDR_W = 4,
  parameter int OUT_W  = 4,
  parameter int SEL_W  = 1,
  localparam int N_COND = 2**SEL_W,
  localparam int WORD_W = OUT_W + 2 + SEL_W + 1 + ADDR_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [N_COND-1:0] x,
  input  logic              start,
  input  logic              abort,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_data,
  output logic [OUT_W-1:0]  out,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] pc
);

  localparam int DEPTH = 2**ADDR_W;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [1:0] OP_NEXT = 2'b00;
  localparam logic [1:0] OP_BR   = 2'b01;
  localparam logic [1:0] OP_WAIT = 2'b10;
  localparam logic [1:0] OP_STOP = 2'b11;

  logic [0:0]        state;
  logic [ADDR_W-1:0] pc_q;
  logic              done_q;

  // Microprogram store; deliberately not reset so programs survive reset_n.
  logic [WORD_W-1:0] mem [0:DEPTH-1];

  logic [WORD_W-1:0] word;
  logic [OUT_W-1:0]  w_out;
  logic [1:0]        w_op;
  logic [SEL_W-1:0]  w_sel;
  logic              w_inv;
  logic [ADDR_W-1:0] w_tgt;
  logic              cond;
  logic [ADDR_W-1:0] pc_inc;
  logic [ADDR_W-1:0] pc_nxt;

  assign word  = mem[pc_q];
  assign w_tgt = word[ADDR_W-1:0];
  assign w_inv = word[ADDR_W];
  assign w_sel = word[ADDR_W+1 +: SEL_W];
  assign w_op  = word[ADDR_W+1+SEL_W +: 2];
  assign w_out = word[WORD_W-1 -: OUT_W];

  assign cond   = x[w_sel] ^ w_inv;
  assign pc_inc = pc_q + ADDR_W'(1);  // wraps naturally at the top address

  always_comb begin
    pc_nxt = pc_inc;
    case (w_op)
      OP_BR:   pc_nxt = cond ? w_tgt : pc_inc;
      OP_WAIT: pc_nxt = cond ? pc_inc : pc_q;
      default: pc_nxt = pc_inc;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= S_IDLE;
      pc_q   <= '0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state <= S_RUN;
            pc_q  <= '0;
          end
        end
        default: begin
          if (abort) begin
            state <= S_IDLE;
            pc_q  <= '0;
          end else if (w_op == OP_STOP) begin
            state  <= S_IDLE;
            pc_q   <= '0;
            done_q <= 1'b1;
          end else begin
            pc_q <= pc_nxt;
          end
        end
      endcase
    end
  end

  // A write coinciding with start lands before word 0 is first read.
  always_ff @(posedge clk) begin
    if (prog_we && state == S_IDLE) mem[prog_addr] <= prog_data;
  end

  assign busy = (state == S_RUN);
  assign out  = busy ? w_out : '0;
  assign done = done_q;
  assign pc   = pc_q;

endmodule

// File: tb/tb_mpa_sequencer.sv
module tb_mpa_sequencer;

  localparam int ADDR_W = 4;
  localparam int OUT_W  = 4;
  localparam int SEL_W  = 1;
  localparam int DEPTH  = 16;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  x;
  logic        start, abort, prog_we;
  logic [3:0]  prog_addr;
  logic [11:0] prog_data;
  logic [3:0]  out;
  logic        busy, done;
  logic [3:0]  pc;

  int checks = 0;
  int failures = 0;

  mpa_sequencer #(.ADDR_W(ADDR_W), .OUT_W(OUT_W), .SEL_W(SEL_W)) dut (
    .clk(clk), .reset_n(reset_n), .x(x), .start(start), .abort(abort),
    .prog_we(prog_we), .prog_addr(prog_addr), .prog_data(prog_data),
    .out(out), .busy(busy), .done(done), .pc(pc)
  );

  always #5 clk = ~clk;

  // Reference model: plain integers, fields decoded arithmetically.
  int m_mem [DEPTH];
  bit m_run;
  int m_pc;
  bit m_done;

  function automatic logic [11:0] mk(int o, int op, int sel, int inv, int tgt);
    return {4'(o), 2'(op), 1'(sel), 1'(inv), 4'(tgt)};
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pc = 0; m_done = 0;
  endtask

  task automatic model_edge(input bit s, input bit a, input bit we,
                            input int ad, input int d, input int xx);
    int w, tgt, inv, sel, op, c;
    m_done = 0;
    if (!m_run) begin
      if (we) m_mem[ad] = d;
      if (s) begin m_run = 1; m_pc = 0; end
    end else if (a) begin
      m_run = 0; m_pc = 0;
    end else begin
      w   = m_mem[m_pc];
      tgt = w % 16;
      inv = (w / 16) % 2;
      sel = (w / 32) % 2;
      op  = (w / 64) % 4;
      c   = ((xx >> sel) & 1) ^ inv;
      if (op == 3) begin
        m_run = 0; m_pc = 0; m_done = 1;
      end else if (op == 1 && c == 1) m_pc = tgt;
      else if (op == 2 && c == 0) m_pc = m_pc;
      else m_pc = (m_pc + 1) % DEPTH;
    end
  endtask

  // One clock: drive inputs, take the edge, advance model, compare at edge+1.
  task automatic cyc(input bit s, input bit a, input bit we, input int ad,
                     input int d, input int xx);
    start = s; abort = a; prog_we = we;
    prog_addr = 4'(ad); prog_data = 12'(d); x = 2'(xx);
    @(posedge clk);
    model_edge(s, a, we, ad, d, xx);
    #1;
    chk("model_out",  int'(out),  m_run ? m_mem[m_pc] / 256 : 0);
    chk("model_busy", int'(busy), int'(m_run));
    chk("model_done", int'(done), int'(m_done));
    chk("model_pc",   int'(pc),   m_pc);
  endtask

  task automatic load(input int ad, input int d);
    cyc(0, 0, 1, ad, d, 0);
  endtask

  task automatic load_prog1();
    load(0, mk(1, 0, 0, 0, 0));
    load(1, mk(3, 2, 0, 0, 0));
    load(2, mk(5, 1, 1, 0, 5));
    load(3, mk(6, 0, 0, 0, 0));
    load(4, mk(7, 3, 0, 0, 0));
    load(5, mk(8, 3, 0, 0, 0));
  endtask

  typedef struct {
    bit       start;
    bit       abort;
    bit [1:0] x;
    int       e_out;
    bit       e_busy;
    bit       e_done;
    int       e_pc;
  } vec_t;

  vec_t nt [9];
  vec_t tk [6];
  vec_t wr [6];

  task automatic run_vec(input string tag, input vec_t v);
    cyc(v.start, v.abort, 0, 0, 0, int'(v.x));
    chk({tag, "_out"},  int'(out),  v.e_out);
    chk({tag, "_busy"}, int'(busy), int'(v.e_busy));
    chk({tag, "_done"}, int'(done), int'(v.e_done));
    chk({tag, "_pc"},   int'(pc),   v.e_pc);
  endtask

  initial begin
    // Branch not taken: x[0] rises after three WAIT-holding cycles.
    nt[0] = '{1, 0, 2'b00, 1, 1, 0, 0};
    nt[1] = '{0, 0, 2'b00, 3, 1, 0, 1};
    nt[2] = '{0, 0, 2'b00, 3, 1, 0, 1};
    nt[3] = '{0, 0, 2'b00, 3, 1, 0, 1};
    nt[4] = '{0, 0, 2'b01, 5, 1, 0, 2};
    nt[5] = '{0, 0, 2'b01, 6, 1, 0, 3};
    nt[6] = '{0, 0, 2'b01, 7, 1, 0, 4};
    nt[7] = '{0, 0, 2'b01, 0, 0, 1, 0};
    nt[8] = '{0, 0, 2'b01, 0, 0, 0, 0};
    // Branch taken: busy drops on the fifth edge counting the start edge.
    tk[0] = '{1, 0, 2'b11, 1, 1, 0, 0};
    tk[1] = '{0, 0, 2'b11, 3, 1, 0, 1};
    tk[2] = '{0, 0, 2'b11, 5, 1, 0, 2};
    tk[3] = '{0, 0, 2'b11, 8, 1, 0, 5};
    tk[4] = '{0, 0, 2'b11, 0, 0, 1, 0};
    tk[5] = '{0, 0, 2'b11, 0, 0, 0, 0};
    // INV + wrap: 0 -> 15 -> 0 ..., then abort without done.
    wr[0] = '{1, 0, 2'b00, 2, 1, 0, 0};
    wr[1] = '{0, 0, 2'b00, 9, 1, 0, 15};
    wr[2] = '{0, 0, 2'b00, 2, 1, 0, 0};
    wr[3] = '{0, 0, 2'b00, 9, 1, 0, 15};
    wr[4] = '{0, 1, 2'b00, 0, 0, 0, 0};
    wr[5] = '{0, 0, 2'b00, 0, 0, 0, 0};

    reset_n = 1'b0; start = 0; abort = 0; prog_we = 0;
    prog_addr = '0; prog_data = '0; x = '0;
    model_reset();
    #12;
    chk("rst_out", int'(out), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_pc", int'(pc), 0);
    reset_n = 1'b1;

    load_prog1();
    for (int i = 0; i < 9; i++) run_vec("br_not_taken", nt[i]);
    for (int i = 0; i < 6; i++) run_vec("br_taken", tk[i]);

    load(15, mk(9, 0, 0, 0, 0));
    load(0, mk(2, 1, 0, 1, 15));
    for (int i = 0; i < 6; i++) run_vec("inv_wrap", wr[i]);

    // Guarding: write and start while busy are both ignored.
    load(0, mk(1, 0, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 3);
    cyc(1, 0, 1, 1, mk(15, 3, 0, 0, 0), 3);
    chk("guard_pc_continues", int'(pc), 1);
    chk("guard_out", int'(out), 3);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0, 0, 0, 3);
    chk("guard_done", int'(done), 1);
    cyc(1, 0, 0, 0, 0, 3);
    cyc(0, 0, 0, 0, 0, 3);
    chk("guard_word1_kept", int'(out), 3);
    cyc(0, 1, 0, 0, 0, 3);

    // abort beats STOP: no done pulse.
    load(0, mk(7, 3, 0, 0, 0));
    cyc(1, 0, 0, 0, 0, 0);
    chk("abort_stop_out", int'(out), 7);
    cyc(0, 1, 0, 0, 0, 0);
    chk("abort_stop_done", int'(done), 0);
    chk("abort_stop_busy", int'(busy), 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("abort_stop_done2", int'(done), 0);
    cyc(0, 1, 0, 0, 0, 0);  // abort in IDLE: nothing happens
    chk("abort_idle_busy", int'(busy), 0);

    // Same-cycle start + write to word 0.
    cyc(1, 0, 1, 0, mk(10, 0, 0, 0, 0), 0);
    chk("start_we_out", int'(out), 10);
    cyc(0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0);
    chk("wait_hold_pc", int'(pc), 1);

    // Async reset mid-run, checked before the next edge.
    reset_n = 1'b0;
    #2;
    model_reset();
    chk("async_out", int'(out), 0);
    chk("async_busy", int'(busy), 0);
    chk("async_done", int'(done), 0);
    chk("async_pc", int'(pc), 0);
    reset_n = 1'b1;
    cyc(0, 0, 0, 0, 0, 0);
    chk("async_no_done", int'(done), 0);
    cyc(1, 0, 0, 0, 0, 0);
    chk("mem_survives_reset", int'(out), 10);
    cyc(0, 1, 0, 0, 0, 0);

    // Randomized: full random program, then random control traffic.
    for (int a = 0; a < DEPTH; a++) load(a, int'($urandom_range(0, 4095)));
    for (int i = 0; i < 600; i++) begin
      cyc(($urandom % 4) == 0, ($urandom % 16) == 0, ($urandom % 4) == 0,
          int'($urandom_range(0, 15)), int'($urandom_range(0, 4095)),
          int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
